// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Two-master arbiter (CPU core and debug/program loader) in
//               front of a single-port memory. Each access is a req/gnt/ack
//               handshake taking one SERVE cycle. Fixed CPU priority with a
//               starvation counter guaranteeing debug service. Defining the
//               macro MEM_ARB_RR_EN replaces that policy with round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int AWIDTH   = 5,
    parameter int DWIDTH   = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [AWIDTH-1:0] cpu_addr,
    input  logic [DWIDTH-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_ack,
    output logic [DWIDTH-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_wr,
    input  logic [AWIDTH-1:0] dbg_addr,
    input  logic [DWIDTH-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_ack,
    output logic [DWIDTH-1:0] dbg_rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_SERVE_CPU = 2'd1;
    localparam logic [1:0] S_SERVE_DBG = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       w_pick_dbg;   // debug port wins the IDLE arbitration

`ifdef MEM_ARB_RR_EN
    logic r_last_dbg;         // 1 = debug port won the most recent grant

    // Contention goes to whichever port did not win last time
    always_comb begin
        w_pick_dbg = dbg_req && (!cpu_req || !r_last_dbg);
    end

    // Remember the winner of every grant
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last_dbg <= 1'b0;
        end else if (r_state == S_IDLE && w_state_nxt != S_IDLE) begin
            r_last_dbg <= (w_state_nxt == S_SERVE_DBG);
        end
    end
`else
    localparam int              WCW         = $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0]  c_max_wait  = WCW'(MAX_WAIT);

    logic [WCW-1:0] r_wait_cnt;

    // CPU wins contention unless debug has already lost MAX_WAIT times
    always_comb begin
        w_pick_dbg = dbg_req && (!cpu_req || (r_wait_cnt == c_max_wait));
    end

    // Count debug's lost arbitrations; clear on grant or when it gives up
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wait_cnt <= '0;
        end else if (!dbg_req || w_state_nxt == S_SERVE_DBG) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_IDLE && w_state_nxt == S_SERVE_CPU &&
                     r_wait_cnt != c_max_wait) begin
            r_wait_cnt <= r_wait_cnt + WCW'(1);
        end
    end
`endif

    // Next state: arbitrate in IDLE, every SERVE cycle returns to IDLE
    always_comb begin
        w_state_nxt = S_IDLE;
        if (r_state == S_IDLE) begin
            if (w_pick_dbg) begin
                w_state_nxt = S_SERVE_DBG;
            end else if (cpu_req) begin
                w_state_nxt = S_SERVE_CPU;
            end
        end
    end

    // Grant and memory-side outputs; reset blocks any memory strobe
    always_comb begin
        cpu_gnt   = 1'b0;
        dbg_gnt   = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (r_state)
            S_SERVE_CPU: begin
                cpu_gnt   = 1'b1;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_wr    = cpu_wr;
                mem_rd    = !cpu_wr;
            end
            S_SERVE_DBG: begin
                dbg_gnt   = 1'b1;
                mem_addr  = dbg_addr;
                mem_wdata = dbg_wdata;
                mem_wr    = dbg_wr;
                mem_rd    = !dbg_wr;
            end
            default: ;
        endcase
        if (!rst) begin
            mem_rd = 1'b0;
            mem_wr = 1'b0;
        end
    end

    // State register, completion pulses and read-data capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            cpu_ack   <= 1'b0;
            dbg_ack   <= 1'b0;
            cpu_rdata <= '0;
            dbg_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            cpu_ack <= (r_state == S_SERVE_CPU);
            dbg_ack <= (r_state == S_SERVE_DBG);
            if (r_state == S_SERVE_CPU && !cpu_wr) begin
                cpu_rdata <= mem_rdata;
            end
            if (r_state == S_SERVE_DBG && !dbg_wr) begin
                dbg_rdata <= mem_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Self-checking bench for mem_bus_arbiter with a 32x8 memory
//               model, a shadow copy for expected data and per-port queues
//               of expected read data consumed on each ack.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_req, cpu_wr, dbg_req, dbg_wr;
    logic [4:0] cpu_addr, dbg_addr;
    logic [7:0] cpu_wdata, dbg_wdata;
    logic       cpu_gnt, cpu_ack, dbg_gnt, dbg_ack;
    logic [7:0] cpu_rdata, dbg_rdata;
    logic       mem_rd, mem_wr;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;

    logic [7:0] mem    [32];
    logic [7:0] shadow [32];
    logic [7:0] cpu_q  [$];
    logic [7:0] dbg_q  [$];
    logic [7:0] exp_cpu_rd = 8'h00;
    logic [7:0] exp_dbg_rd = 8'h00;

    int n_checks = 0;
    int n_errors = 0;

    mem_bus_arbiter #(.AWIDTH(5), .DWIDTH(8), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_wr(dbg_wr), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: synchronous write, combinational read
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every ack consumes one expected read-data entry
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (cpu_ack === 1'b1) begin
                if (cpu_q.size() == 0) check("cpu_ack_unexpected", 1, 0);
                else                   check("cpu_rdata", cpu_rdata, cpu_q.pop_front());
            end
            if (dbg_ack === 1'b1) begin
                if (dbg_q.size() == 0) check("dbg_ack_unexpected", 1, 0);
                else                   check("dbg_rdata", dbg_rdata, dbg_q.pop_front());
            end
        end
    end

    // One access from the IDLE cycle through its ack; req is left high on return
    task automatic access(input bit dbg, input bit wr, input logic [4:0] a, input logic [7:0] d);
        logic [7:0] e;
        if (dbg) begin
            dbg_req = 1'b1; dbg_wr = wr; dbg_addr = a; dbg_wdata = d;
        end else begin
            cpu_req = 1'b1; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
        end
        if (wr) begin
            shadow[a] = d;
            e = dbg ? exp_dbg_rd : exp_cpu_rd;
        end else begin
            e = shadow[a];
            if (dbg) exp_dbg_rd = e; else exp_cpu_rd = e;
        end
        if (dbg) dbg_q.push_back(e); else cpu_q.push_back(e);
        check("idle_gnt", dbg ? dbg_gnt : cpu_gnt, 0);
        @(posedge clk); #1;
        check("gnt", dbg ? dbg_gnt : cpu_gnt, 1);
        check("other_gnt", dbg ? cpu_gnt : dbg_gnt, 0);
        check("ack_early", dbg ? dbg_ack : cpu_ack, 0);
        check("mem_wr", mem_wr, wr);
        check("mem_rd", mem_rd, !wr);
        check("mem_addr", mem_addr, a);
        check("mem_wdata", mem_wdata, d);
        @(posedge clk); #1;
        check("ack", dbg ? dbg_ack : cpu_ack, 1);
        check("gnt_in_ack", dbg ? dbg_gnt : cpu_gnt, 0);
    endtask

    task automatic drop_all();
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        @(posedge clk); #1;
    endtask

    function automatic bit exp_dbg_win(input int k);
`ifdef MEM_ARB_RR_EN
        return (k % 2) == 1;
`else
        return (k % 5) == 4;
`endif
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ngr;
        for (int i = 0; i < 32; i++) shadow[i] = 8'h00;

        // Reset with a CPU write request pending: no strobe, no ack
        rst = 1'b0;
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 5'd3; cpu_wdata = 8'hFF;
        dbg_req = 1'b0; dbg_wr = 1'b0; dbg_addr = 5'd0; dbg_wdata = 8'h00;
        @(negedge clk);
        check("rst_mem_wr0", mem_wr, 0);
        check("rst_mem_rd0", mem_rd, 0);
        @(posedge clk); @(negedge clk);
        check("rst_mem_wr1", mem_wr, 0);
        check("rst_cpu_ack", cpu_ack, 0);
        check("rst_cpu_gnt", cpu_gnt, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = 5'd0; cpu_wdata = 8'h00;
        check("rel_cpu_gnt", cpu_gnt, 0);
        check("rel_dbg_gnt", dbg_gnt, 0);
        check("rel_cpu_ack", cpu_ack, 0);
        check("rel_dbg_ack", dbg_ack, 0);
        check("rel_cpu_rdata", cpu_rdata, 0);
        check("rel_dbg_rdata", dbg_rdata, 0);
        check("rel_mem_strobes", {mem_rd, mem_wr}, 0);
        check("rel_mem_addr", mem_addr, 0);
        check("rel_mem_wdata", mem_wdata, 0);
        @(posedge clk); #1;
        check("idle_no_req", {cpu_gnt, dbg_gnt}, 0);

        // CPU write then back-to-back read presented during the ack cycle
        access(0, 1, 5'd5, 8'hA5);
        access(0, 0, 5'd5, 8'h00);
        drop_all();

        // Request held through the ack cycle is a new request
        access(0, 0, 5'd5, 8'h00);
        access(0, 0, 5'd5, 8'h00);
        drop_all();

        // Preload words used later
        access(0, 1, 5'd2,  8'h42); drop_all();
        access(0, 1, 5'd9,  8'h99); drop_all();
        access(0, 1, 5'd16, 8'h11); drop_all();
        access(0, 1, 5'd31, 8'h3C); drop_all();

        // Debug write seen by CPU, then debug read of the top word
        access(1, 1, 5'd7, 8'h5A);  drop_all();
        access(0, 0, 5'd7, 8'h00);  drop_all();
        access(1, 0, 5'd31, 8'h00); drop_all();

        // Both ports requesting continuously: check grant order
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 5'd2; cpu_wdata = 8'h00;
        dbg_req = 1'b1; dbg_wr = 1'b0; dbg_addr = 5'd9; dbg_wdata = 8'h00;
        exp_cpu_rd = shadow[2];
        exp_dbg_rd = shadow[9];
        for (int k = 0; k < 10; k++) begin
            if (exp_dbg_win(k)) dbg_q.push_back(shadow[9]);
            else                cpu_q.push_back(shadow[2]);
        end
        ngr = 0;
        for (int cyc = 0; cyc < 60 && ngr < 10; cyc++) begin
            @(posedge clk); #1;
            if (cpu_gnt || dbg_gnt) begin
                check($sformatf("arb_order_%0d", ngr), {cpu_gnt, dbg_gnt},
                      exp_dbg_win(ngr) ? 2'b01 : 2'b10);
                ngr++;
                if (ngr == 10) begin
                    cpu_req = 1'b0;
                    dbg_req = 1'b0;
                end
            end
        end
        if (ngr < 10) check("arb_timeout", ngr, 10);
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset during a debug write: memory untouched, no ack
        dbg_req = 1'b1; dbg_wr = 1'b1; dbg_addr = 5'd16; dbg_wdata = 8'h77;
        @(posedge clk); #1;
        check("rst_serve_gnt", dbg_gnt, 1);
        rst = 1'b0;
        @(negedge clk);
        check("rst_serve_mem_wr", mem_wr, 0);
        @(posedge clk); #1;
        dbg_req = 1'b0;
        check("rst_serve_ack", dbg_ack, 0);
        check("rst_serve_state", {cpu_gnt, dbg_gnt}, 0);
        check("rst_serve_dbg_rdata", dbg_rdata, 0);
        check("rst_serve_cpu_rdata", cpu_rdata, 0);
        check("rst_serve_mem", mem[16], shadow[16]);
        exp_cpu_rd = 8'h00;
        exp_dbg_rd = 8'h00;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ack", dbg_ack, 0);
        access(0, 0, 5'd16, 8'h00); drop_all();
        @(posedge clk); #1;

        check("cpu_q_drained", cpu_q.size(), 0);
        check("dbg_q_drained", dbg_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
